// File: rtl/axicb_arb_pkg.sv
// axicb_arb_pkg: shared state type, default priority width and one-hot decode
// used by the crossbar request arbiter.
package axicb_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    localparam int PRIO_W_DEFAULT = 2;

    // Grant vectors are one-hot, so OR-ing the set indices yields the index.
    function automatic logic [3:0] oh2idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++)
            idx = oh[i] ? (idx | 4'(i)) : idx;
        return idx;
    endfunction

endpackage

// File: rtl/axicb_rr_picker.sv
// axicb_rr_picker: picks the first request strictly above ptr_i, wrapping,
// via a priority encoder over the request vector duplicated to double width.
module axicb_rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [2*N-1:0] dbl;

    always_comb begin
        dbl   = {req_i, req_i};
        gnt_o = '0;
        for (int i = 2*N-1; i >= 0; i--)
            gnt_o = (dbl[i] && i > int'(ptr_i)) ? (N'(1) << (i % N)) : gnt_o;
    end

endmodule

// File: rtl/axicb_req_arbiter.sv
// axicb_req_arbiter: round-robin merge of NB_REQ valid/ready streams, grant locked per burst.
// Define AXICB_ARB_PRIO_EN to add i_prio and pre-filter to the highest valid priority.
module axicb_req_arbiter
    import axicb_arb_pkg::*;
#(
    parameter int NB_REQ     = 4,
    parameter int DATA_BUS_W = 8
`ifdef AXICB_ARB_PRIO_EN
    , parameter int PRIO_W   = PRIO_W_DEFAULT
`endif
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         srst,
    input  logic [NB_REQ-1:0]            i_valid,
    output logic [NB_REQ-1:0]            i_ready,
    input  logic [NB_REQ*DATA_BUS_W-1:0] i_data,
    input  logic [NB_REQ-1:0]            i_last,
`ifdef AXICB_ARB_PRIO_EN
    input  logic [NB_REQ*PRIO_W-1:0]     i_prio,
`endif
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [DATA_BUS_W-1:0]        o_data,
    output logic                         o_last,
    output logic [NB_REQ-1:0]            o_grant,
    output logic                         busy
);

    localparam int PTR_W = $clog2(NB_REQ);

    arb_state_e        state_q, state_d;
    logic [NB_REQ-1:0] gnt_q, gnt_d, cand, win;
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic              hs_last;

`ifdef AXICB_ARB_PRIO_EN
    logic [PRIO_W-1:0] top;

    always_comb begin
        top  = '0;
        cand = '0;
        for (int k = 0; k < NB_REQ; k++)
            top = (i_valid[k] && i_prio[k*PRIO_W +: PRIO_W] > top) ? i_prio[k*PRIO_W +: PRIO_W] : top;
        for (int k = 0; k < NB_REQ; k++)
            cand[k] = i_valid[k] && (i_prio[k*PRIO_W +: PRIO_W] == top);
    end
`else
    assign cand = i_valid;
`endif

    axicb_rr_picker #(.N(NB_REQ), .PW(PTR_W)) u_pick (
        .req_i (cand),
        .ptr_i (rr_q),
        .gnt_o (win)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            rr_q    <= PTR_W'(NB_REQ - 1);
        end else if (srst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            rr_q    <= PTR_W'(NB_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

    // A presented but unfinished beat locks its winner so valid/data stay stable.
    always_comb begin
        hs_last = o_valid && o_ready && o_last;
        rr_d    = hs_last ? PTR_W'(oh2idx(16'(o_grant))) : rr_q;
        state_d = state_q;
        gnt_d   = gnt_q;
        if (state_q == ARB_IDLE) begin
            state_d = (o_valid && !hs_last) ? ARB_LOCKED : ARB_IDLE;
            gnt_d   = (o_valid && !hs_last) ? win : '0;
        end else if (hs_last) begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
        end
    end

    always_comb begin
        o_grant = (state_q == ARB_LOCKED) ? gnt_q : win;
        o_valid = |(i_valid & o_grant);
        o_data  = '0;
        o_last  = 1'b0;
        for (int k = 0; k < NB_REQ; k++) begin
            o_data = o_grant[k] ? (o_data | i_data[k*DATA_BUS_W +: DATA_BUS_W]) : o_data;
            o_last = o_last | (o_grant[k] & i_last[k]);
        end
        i_ready = o_grant & {NB_REQ{o_ready}};
        busy    = (state_q == ARB_LOCKED);
    end

endmodule

// File: tb/tb_axicb_req_arbiter.sv
// tb_axicb_req_arbiter: directed plus randomized check of the burst-locking round-robin
// arbiter against a behavioural model; define AXICB_ARB_PRIO_EN to cover priorities.
module tb_axicb_req_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           aclk = 1'b0, aresetn = 1'b0, srst = 1'b0, o_ready = 1'b0;
    logic [N-1:0]   i_valid = '0, i_last = '0;
    logic [N*W-1:0] i_data = '0;
    logic [N-1:0]   i_ready, o_grant;
    logic           o_valid, o_last, busy;
    logic [W-1:0]   o_data;
`ifdef AXICB_ARB_PRIO_EN
    logic [2*N-1:0] i_prio = '0;
`endif

    int n_chk = 0, n_fail = 0;

    // Model: locked flag, locked owner, index of the last completed burst's owner.
    bit m_lock = 1'b0;
    int m_own  = 0;
    int m_ptr  = N - 1;
    int s_win;
    bit s_ev, s_last;
    logic [N-1:0] s_hs = '0;

    always #5 aclk = ~aclk;

    axicb_req_arbiter #(.NB_REQ(N), .DATA_BUS_W(W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_last  (i_last),
`ifdef AXICB_ARB_PRIO_EN
        .i_prio  (i_prio),
`endif
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_grant (o_grant),
        .busy    (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick();
`ifdef AXICB_ARB_PRIO_EN
        int top = 0;
`endif
        if (m_lock) return m_own;
`ifdef AXICB_ARB_PRIO_EN
        for (int k = 0; k < N; k++)
            if (i_valid[k] && int'(i_prio[k*2 +: 2]) > top) top = int'(i_prio[k*2 +: 2]);
`endif
        for (int j = 1; j <= N; j++) begin
            int k;
            k = (m_ptr + j) % N;
`ifdef AXICB_ARB_PRIO_EN
            if (i_valid[k] && int'(i_prio[k*2 +: 2]) == top) return k;
`else
            if (i_valid[k]) return k;
`endif
        end
        return -1;
    endfunction

    task automatic compare();
        logic [N-1:0] g;
        logic [W-1:0] d;
        logic el;
        s_win = pick();
        g = '0; d = '0; el = 1'b0; s_ev = 1'b0;
        if (s_win >= 0) begin
            g[s_win] = 1'b1;
            s_ev = i_valid[s_win];
            d = i_data[s_win*W +: W];
            el = i_last[s_win];
        end
        chk("o_grant", 32'(o_grant), 32'(g));
        chk("o_valid", 32'(o_valid), 32'(s_ev));
        chk("o_data", 32'(o_data), 32'(d));
        chk("o_last", 32'(o_last), 32'(el));
        chk("i_ready", 32'(i_ready), 32'(o_ready ? g : '0));
        chk("busy", 32'(busy), 32'(m_lock));
        s_last = s_ev && o_ready && el;
        s_hs = (s_ev && o_ready) ? g : '0;
    endtask

    task automatic eval();
        #1;
        compare();
    endtask

    task automatic adv();
        @(posedge aclk);
        if (!aresetn || srst) begin
            m_lock = 1'b0;
            m_ptr = N - 1;
        end else if (!m_lock) begin
            if (s_last) m_ptr = s_win;
            else if (s_ev) begin
                m_lock = 1'b1;
                m_own = s_win;
            end
        end else if (s_last) begin
            m_lock = 1'b0;
            m_ptr = m_own;
        end
        @(negedge aclk);
    endtask

    initial begin
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        o_ready = 1'b1;
        eval();
        chk("idle_valid", 32'(o_valid), 32'd0);
        chk("idle_grant", 32'(o_grant), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(i_ready), 32'd0);
        adv();

        i_valid = 4'hF; i_last = 4'hF; i_data = 32'h33221100;
        for (int c = 0; c < 5; c++) begin
            eval();
            chk("rr_seq", 32'(o_grant), 32'd1 << (c % 4));
            chk("rr_acc", 32'(i_ready & i_valid), 32'd1 << (c % 4));
            adv();
        end

        i_valid = 4'b0110; i_last = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) i_last[1] = 1'b1;
            if (c == 3) i_valid[1] = 1'b0;
            i_data[15:8] = 8'(8'h50 + c);
            eval();
            chk("burst_grant", 32'(o_grant), (c < 3) ? 32'h2 : 32'h4);
            chk("burst_busy", 32'(busy), (c == 1 || c == 2) ? 32'd1 : 32'd0);
            adv();
        end

        i_valid = 4'b1000; i_last = 4'b1001; o_ready = 1'b0; i_data = 32'hA3000000;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) i_valid[0] = 1'b1;
            eval();
            chk("stall_grant", 32'(o_grant), 32'h8);
            chk("stall_data", 32'(o_data), 32'hA3);
            adv();
        end
        o_ready = 1'b1;
        eval();
        chk("stall_accept", 32'(i_ready), 32'h8);
        adv();
        i_valid = 4'b0001;
        eval();
        chk("after_stall", 32'(o_grant), 32'h1);
        adv();

        i_valid = 4'b0100; i_last = 4'b0000; o_ready = 1'b0;
        eval();
        chk("pre_srst_grant", 32'(o_grant), 32'h4);
        adv();
        srst = 1'b1;
        eval();
        chk("pre_srst_busy", 32'(busy), 32'd1);
        adv();
        srst = 1'b0; i_valid = 4'hF; i_last = 4'hF; o_ready = 1'b1;
        eval();
        chk("post_srst_busy", 32'(busy), 32'd0);
        chk("post_srst_grant", 32'(o_grant), 32'h1);
        adv();

`ifdef AXICB_ARB_PRIO_EN
        i_valid = 4'b1001; i_prio = 8'b01_00_00_00;
        for (int c = 0; c < 3; c++) begin
            eval();
            chk("prio_grant", 32'(o_grant), 32'h8);
            adv();
        end
        i_valid = 4'b0001;
        eval();
        chk("prio_drop", 32'(o_grant), 32'h1);
        adv();
        i_prio = '0;
`endif
        i_valid = '0;
        s_hs = '0;

        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < N; k++)
                if (!i_valid[k] || s_hs[k]) begin
                    i_valid[k] = ($urandom_range(0, 2) != 0);
                    i_last[k] = ($urandom_range(0, 2) == 0);
                    i_data[k*W +: W] = 8'($urandom);
                end
            o_ready = ($urandom_range(0, 3) != 0);
            srst = ($urandom_range(0, 99) == 0);
`ifdef AXICB_ARB_PRIO_EN
            i_prio = 8'($urandom);
`endif
            eval();
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
